// File: rtl/dram_pkg.sv
// Shared types and default timing constants for the DRAM timing controller.
package dram_pkg;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ACT = 3'd1,
        RD  = 3'd2,
        WR  = 3'd3,
        PRE = 3'd4,
        REF = 3'd5
    } dram_cmd_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACT_WAIT = 3'd1,
        RD_WAIT  = 3'd2,
        RD_BURST = 3'd3,
        WR_WAIT  = 3'd4,
        WR_BURST = 3'd5,
        PRE_WAIT = 3'd6,
        REF_WAIT = 3'd7
    } timing_state_t;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_REFI_W  = 16;
    localparam int DEF_T_RCD   = 4;
    localparam int DEF_T_CL    = 5;
    localparam int DEF_T_CWL   = 4;
    localparam int DEF_T_BURST = 4;
    localparam int DEF_T_RP    = 4;
    localparam int DEF_T_RFC   = 16;
    localparam int DEF_T_REFI  = 100;

endpackage

// File: rtl/refresh_timer.sv
// Free-running refresh-interval down-counter and sticky refresh request.
// Only instantiated when DRAM_AUTO_REFRESH_EN is defined.
module refresh_timer
    import dram_pkg::*;
#(
    parameter int REFI_W = DEF_REFI_W,
    parameter int T_REFI = DEF_T_REFI
) (
    input  logic CLK,
    input  logic nRST,
    input  logic ref_done,
    output logic rf_req
);

    localparam logic [REFI_W-1:0] RELOAD = REFI_W'(T_REFI - 1);
    localparam logic [REFI_W-1:0] ONE    = REFI_W'(1);

    logic [REFI_W-1:0] refi_cnt_q, refi_cnt_d;
    logic              rf_req_q, rf_req_d;
    logic              expire;

    // An expiry wins over a simultaneous ref_done so a new interval is never lost.
    always_comb begin
        expire     = (refi_cnt_q == '0);
        refi_cnt_d = expire ? RELOAD : (refi_cnt_q - ONE);
        rf_req_d   = rf_req_q;
        if (expire) begin
            rf_req_d = 1'b1;
        end else if (ref_done) begin
            rf_req_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            refi_cnt_q <= RELOAD;
            rf_req_q   <= 1'b0;
        end else begin
            refi_cnt_q <= refi_cnt_d;
            rf_req_q   <= rf_req_d;
        end
    end

    assign rf_req = rf_req_q;

endmodule

// File: rtl/dram_timing_ctrl.sv
// Times issued DRAM commands, returns done pulses and burst windows.
// Automatic refresh requests are compiled in only with DRAM_AUTO_REFRESH_EN.
//
// state    | meaning
// IDLE     | waiting for cmd_issue
// ACT_WAIT | counting tRCD after ACT
// RD_WAIT  | counting CAS latency before the read burst
// RD_BURST | rd_en window, T_BURST cycles
// WR_WAIT  | counting CAS write latency before the write burst
// WR_BURST | wr_en window, T_BURST cycles
// PRE_WAIT | counting tRP after PRE
// REF_WAIT | counting tRFC after REF
module dram_timing_ctrl
    import dram_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int REFI_W  = DEF_REFI_W,
    parameter int T_RCD   = DEF_T_RCD,
    parameter int T_CL    = DEF_T_CL,
    parameter int T_CWL   = DEF_T_CWL,
    parameter int T_BURST = DEF_T_BURST,
    parameter int T_RP    = DEF_T_RP,
    parameter int T_RFC   = DEF_T_RFC,
    parameter int T_REFI  = DEF_T_REFI
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       cmd_issue,
    input  logic [2:0] cmd,
    output logic       tACT_done,
    output logic       tWR_done,
    output logic       tRD_done,
    output logic       tPRE_done,
    output logic       tREF_done,
    output logic       rf_req,
    output logic       wr_en,
    output logic       rd_en,
    output logic       clear,
    output logic       busy
);

    if (T_RCD < 1 || T_CL < 1 || T_CWL < 1 || T_BURST < 1 ||
        T_RP < 1 || T_RFC < 1 || T_REFI < 1) begin : g_bad_min
        $error("dram_timing_ctrl: every timing parameter must be >= 1");
    end
    if (longint'(T_RCD) >= (longint'(1) << CNT_W) || longint'(T_CL) >= (longint'(1) << CNT_W) ||
        longint'(T_CWL) >= (longint'(1) << CNT_W) || longint'(T_BURST) >= (longint'(1) << CNT_W) ||
        longint'(T_RP) >= (longint'(1) << CNT_W) || longint'(T_RFC) >= (longint'(1) << CNT_W) ||
        longint'(T_REFI) >= (longint'(1) << REFI_W)) begin : g_bad_width
        $error("dram_timing_ctrl: timing parameter does not fit its counter");
    end

    localparam logic [CNT_W-1:0] LD_RCD   = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] LD_CL    = CNT_W'(T_CL - 1);
    localparam logic [CNT_W-1:0] LD_CWL   = CNT_W'(T_CWL - 1);
    localparam logic [CNT_W-1:0] LD_BURST = CNT_W'(T_BURST - 1);
    localparam logic [CNT_W-1:0] LD_RP    = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_RFC   = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    timing_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             act_done_q, act_done_d;
    logic             wr_done_q, wr_done_d;
    logic             rd_done_q, rd_done_d;
    logic             pre_done_q, pre_done_d;
    logic             ref_done_q, ref_done_d;
    logic             wr_en_q, wr_en_d;
    logic             rd_en_q, rd_en_d;
    logic             clear_q, clear_d;
    logic             busy_q, busy_d;
    logic             last_d;

    // The last latency cycle hands straight to the burst so the data window
    // opens exactly T_CL/T_CWL cycles after issue.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_issue) begin
                    case (dram_cmd_t'(cmd))
                        ACT: begin
                            state_d = ACT_WAIT;
                            cnt_d   = LD_RCD;
                        end
                        RD: begin
                            state_d = (T_CL == 1) ? RD_BURST : RD_WAIT;
                            cnt_d   = (T_CL == 1) ? LD_BURST : LD_CL;
                        end
                        WR: begin
                            state_d = (T_CWL == 1) ? WR_BURST : WR_WAIT;
                            cnt_d   = (T_CWL == 1) ? LD_BURST : LD_CWL;
                        end
                        PRE: begin
                            state_d = PRE_WAIT;
                            cnt_d   = LD_RP;
                        end
                        REF: begin
                            state_d = REF_WAIT;
                            cnt_d   = LD_RFC;
                        end
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (cnt_q <= ONE) begin
                    state_d = (state_q == RD_WAIT) ? RD_BURST : WR_BURST;
                    cnt_d   = LD_BURST;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ACT_WAIT, PRE_WAIT, REF_WAIT, RD_BURST, WR_BURST: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        last_d     = (cnt_d == '0);
        act_done_d = (state_d == ACT_WAIT) && last_d;
        pre_done_d = (state_d == PRE_WAIT) && last_d;
        ref_done_d = (state_d == REF_WAIT) && last_d;
        rd_done_d  = (state_d == RD_BURST) && last_d;
        wr_done_d  = (state_d == WR_BURST) && last_d;
        rd_en_d    = (state_d == RD_BURST);
        wr_en_d    = (state_d == WR_BURST);
        clear_d    = act_done_d | pre_done_d | ref_done_d | rd_done_d | wr_done_d;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            act_done_q <= 1'b0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            pre_done_q <= 1'b0;
            ref_done_q <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            clear_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_done_q <= act_done_d;
            wr_done_q  <= wr_done_d;
            rd_done_q  <= rd_done_d;
            pre_done_q <= pre_done_d;
            ref_done_q <= ref_done_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            clear_q    <= clear_d;
            busy_q     <= busy_d;
        end
    end

`ifdef DRAM_AUTO_REFRESH_EN
    refresh_timer #(
        .REFI_W (REFI_W),
        .T_REFI (T_REFI)
    ) u_refresh_timer (
        .CLK      (CLK),
        .nRST     (nRST),
        .ref_done (ref_done_q),
        .rf_req   (rf_req)
    );
`else
    assign rf_req = 1'b0;
`endif

    assign tACT_done = act_done_q;
    assign tWR_done  = wr_done_q;
    assign tRD_done  = rd_done_q;
    assign tPRE_done = pre_done_q;
    assign tREF_done = ref_done_q;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign clear     = clear_q;
    assign busy      = busy_q;

endmodule
